dco_word_seq: RTL

Tuning-word sequencer sitting directly upstream of the three row/column coders that drive the DCO capacitor banks. It takes the signed loop-filter correction and steers it into the large, medium and small bank words in turn: PVT, then acquisition, then tracking. It freezes each bank once the correction has settled, and reports the active mode and a lock flag. In tracking mode it optionally dithers the fractional correction bits onto the small bank with a first-order sigma-delta.

---
 rtl/dco_word_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dco_word_seq.sv
// DCO tuning-word sequencer: steers the loop correction into the large, medium
// and small capacitor-bank words (PVT -> ACQ -> TRK). Optional dither: DCO_DITHER_EN.
module dco_word_seq #(
  parameter int FRAC_W     = 4,
  parameter int SETTLE_CYC = 16,
  parameter int TOL        = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                otw_valid,
  input  logic [9+FRAC_W:0]   otw,
  output logic [4:0]          c_l_word,
  output logic [7:0]          c_m_word,
  output logic [7:0]          c_s_word,
  output logic [1:0]          mode,
  output logic                lock
);

  localparam int CW = $clog2(SETTLE_CYC) + 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PVT  = 2'd1,
    ACQ  = 2'd2,
    TRK  = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic signed [9:0]  prev;
  logic               first;
  logic [7:0]         c_s_base;

  function automatic logic [4:0] sat5(input logic signed [11:0] v);
    if (v < 12'sd0)       sat5 = 5'd0;
    else if (v > 12'sd31) sat5 = 5'd31;
    else                  sat5 = v[4:0];
  endfunction

  function automatic logic [7:0] sat8(input logic signed [11:0] v);
    if (v < 12'sd0)        sat8 = 8'd0;
    else if (v > 12'sd255) sat8 = 8'd255;
    else                   sat8 = v[7:0];
  endfunction

  logic signed [9:0]  oi;
  logic signed [11:0] oi_x;
  logic signed [10:0] diff;
  logic               in_tol;
  logic [CW-1:0]      cnt_inc;
  logic               hit;

  assign oi      = otw[9+FRAC_W:FRAC_W];
  assign oi_x    = {{2{oi[9]}}, oi};
  assign diff    = {oi[9], oi} - {prev[9], prev};
  assign in_tol  = (diff <= 11'(TOL)) && (diff >= -11'(TOL));
  assign cnt_inc = (cnt >= CNT_TOP) ? CNT_TOP : cnt + CW'(1);
  assign hit     = !first && in_tol && (cnt_inc == CNT_TOP);
  assign mode    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      c_l_word <= 5'd16;
      c_m_word <= 8'd128;
      c_s_base <= 8'd128;
      lock     <= 1'b0;
      cnt      <= '0;
      prev     <= '0;
      first    <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      lock  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= PVT;
          cnt   <= '0;
          first <= 1'b1;
        end
        default: begin
          if (otw_valid) begin
            case (state)
              PVT:     c_l_word <= sat5(12'sd16 + oi_x);
              ACQ:     c_m_word <= sat8(12'sd128 + oi_x);
              default: c_s_base <= sat8(12'sd128 + oi_x);
            endcase
            prev <= oi;
            if (first) begin
              cnt   <= '0;
              first <= 1'b0;
            end else if (!in_tol) begin
              cnt <= '0;
              if (state == TRK) lock <= 1'b0;
            end else if (hit && state != TRK) begin
              // Settled in PVT/ACQ: hand over to the next finer bank
              state <= (state == PVT) ? ACQ : TRK;
              cnt   <= '0;
              first <= 1'b1;
            end else begin
              cnt <= cnt_inc;
              if (hit) lock <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef DCO_DITHER_EN
  logic [FRAC_W-1:0] frac;
  logic [FRAC_W-1:0] acc;
  logic              carry;

  // First-order sigma-delta of the latched fraction, live only in TRK
  always_ff @(posedge clk) begin
    if (rst) begin
      frac  <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else begin
      if (en && otw_valid && state != IDLE) frac <= otw[FRAC_W-1:0];
      if (state != TRK) begin
        acc   <= '0;
        carry <= 1'b0;
      end else begin
        {carry, acc} <= {1'b0, acc} + {1'b0, frac};
      end
    end
  end

  assign c_s_word = carry ? sat8({4'd0, c_s_base} + 12'sd1) : c_s_base;
`else
  logic unused_frac;
  assign unused_frac = ^otw[FRAC_W-1:0];
  assign c_s_word    = c_s_base;
`endif

endmodule
